// File: rtl/gfx_pkg.sv
// Shared vertex types and the FSM state encoding for the triangle front end.
package gfx_pkg;

    localparam int unsigned COORD_W     = 9;
    localparam int unsigned VERT_WORD_W = 27;

    typedef logic [COORD_W-1:0] coord_t;
    typedef coord_t vertex_t [2:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_DONE
    } issuer_state_t;

    // Memory word layout is {z, y, x}; index 0 is x.
    function automatic void unpack_vertex(input logic [VERT_WORD_W-1:0] word, output vertex_t v);
        v[0] = word[8:0];
        v[1] = word[17:9];
        v[2] = word[26:18];
    endfunction

endpackage

// File: rtl/vertex_fetch.sv
// Issues three consecutive vertex reads and captures each word MEM_LATENCY cycles
// later, steered by a tag that travels alongside the read.
module vertex_fetch
    import gfx_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   go,
    input  logic [ADDR_W-1:0]      base,
    input  logic [VERT_WORD_W-1:0] mem_data_in,
    output logic [ADDR_W-1:0]      mem_addr_out,
    output logic                   mem_rd_out,
    output vertex_t                v1_c,
    output vertex_t                v2_c,
    output vertex_t                v3_c,
    output logic                   fetch_done_c
);

    logic       rd_k_last;
    logic [1:0] rd_k;
    logic       tag_vld [MEM_LATENCY];
    logic [1:0] tag_k   [MEM_LATENCY];
    vertex_t    vert_q  [3];
    vertex_t    word_v;
    vertex_t    verts_c [3];
    logic       cap;
    logic [1:0] cap_k;

    assign rd_k_last = (rd_k == 2'd2);
    assign cap       = tag_vld[MEM_LATENCY-1];
    assign cap_k     = tag_k[MEM_LATENCY-1];

    // Read sequencer: three back-to-back strobes starting at base.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            mem_rd_out   <= 1'b0;
            mem_addr_out <= '0;
            rd_k         <= '0;
        end else if (go) begin
            mem_rd_out   <= 1'b1;
            mem_addr_out <= base;
            rd_k         <= '0;
        end else if (mem_rd_out) begin
            if (rd_k_last) begin
                mem_rd_out <= 1'b0;
            end else begin
                rd_k         <= rd_k + 2'd1;
                mem_addr_out <= mem_addr_out + ADDR_W'(1);
            end
        end
    end

    // Tag pipe plus capture registers; reset flushes any read still in flight.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < int'(MEM_LATENCY); i++) begin
                tag_vld[i] <= 1'b0;
                tag_k[i]   <= '0;
            end
            for (int k = 0; k < 3; k++) begin
                for (int c = 0; c < 3; c++) begin
                    vert_q[k][c] <= '0;
                end
            end
        end else begin
            tag_vld[0] <= mem_rd_out;
            tag_k[0]   <= rd_k;
            for (int i = 1; i < int'(MEM_LATENCY); i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_k[i]   <= tag_k[i-1];
            end
            for (int k = 0; k < 3; k++) begin
                if (cap && (cap_k == 2'(k))) begin
                    vert_q[k] <= word_v;
                end
            end
        end
    end

    // Bypass the word being captured so the last vertex is usable in the same cycle.
    always_comb begin
        unpack_vertex(mem_data_in, word_v);
        for (int k = 0; k < 3; k++) begin
            verts_c[k] = vert_q[k];
            if (cap && (cap_k == 2'(k))) begin
                verts_c[k] = word_v;
            end
        end
    end

    assign v1_c         = verts_c[0];
    assign v2_c         = verts_c[1];
    assign v3_c         = verts_c[2];
    assign fetch_done_c = cap && (cap_k == 2'd2);

endmodule

// File: rtl/triangle_issuer.sv
// Walks the triangle list, hands one triangle at a time to the shader and
// forwards each {index, color} result, with a watchdog for lost results.
module triangle_issuer
    import gfx_pkg::*;
#(
    parameter  int unsigned NUM_TRIS    = 16,
    parameter  int unsigned ADDR_W      = 8,
    parameter  int unsigned MEM_LATENCY = 2,
    parameter  int unsigned TIMEOUT     = 64,
    localparam int unsigned TRI_W       = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    output logic                   busy_out,
    output logic                   done_out,
    output logic [ADDR_W-1:0]      mem_addr_out,
    output logic                   mem_rd_out,
    input  logic [VERT_WORD_W-1:0] mem_data_in,
    output logic [8:0]             v1_out [2:0],
    output logic [8:0]             v2_out [2:0],
    output logic [8:0]             v3_out [2:0],
    output logic                   data_valid_out,
    input  logic                   shader_valid_in,
    input  logic [7:0]             shader_color_in,
    output logic                   color_valid_out,
    output logic [7:0]             color_out,
    output logic [TRI_W-1:0]       tri_idx_out,
    output logic                   timeout_out
);

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TRI_W-1:0] LAST_IDX = TRI_W'((NUM_TRIS > 0) ? NUM_TRIS - 1 : 0);

    issuer_state_t     state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [TRI_W-1:0]  tri_idx_d;
    logic              busy_d, done_d, dv_d, cv_d, timeout_d;
    logic [7:0]        color_d;
    logic              fetch_go_c;
    logic              fetch_done_c;
    vertex_t           f_v1, f_v2, f_v3;

    vertex_fetch #(
        .ADDR_W      (ADDR_W),
        .MEM_LATENCY (MEM_LATENCY)
    ) u_fetch (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .go           (fetch_go_c),
        .base         (base_d),
        .mem_data_in  (mem_data_in),
        .mem_addr_out (mem_addr_out),
        .mem_rd_out   (mem_rd_out),
        .v1_c         (f_v1),
        .v2_c         (f_v2),
        .v3_c         (f_v3),
        .fetch_done_c (fetch_done_c)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q         <= S_IDLE;
            base_q          <= '0;
            wd_q            <= '0;
            tri_idx_out     <= '0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            data_valid_out  <= 1'b0;
            color_valid_out <= 1'b0;
            color_out       <= '0;
            timeout_out     <= 1'b0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            wd_q            <= wd_d;
            tri_idx_out     <= tri_idx_d;
            busy_out        <= busy_d;
            done_out        <= done_d;
            data_valid_out  <= dv_d;
            color_valid_out <= cv_d;
            color_out       <= color_d;
            timeout_out     <= timeout_d;
        end
    end

    // Vertices are frozen when the fetch completes and held until the next one.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int c = 0; c < 3; c++) begin
                v1_out[c] <= '0;
                v2_out[c] <= '0;
                v3_out[c] <= '0;
            end
        end else if (fetch_done_c) begin
            v1_out <= f_v1;
            v2_out <= f_v2;
            v3_out <= f_v3;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        wd_d       = wd_q;
        tri_idx_d  = tri_idx_out;
        busy_d     = busy_out;
        color_d    = color_out;
        timeout_d  = timeout_out;
        fetch_go_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    tri_idx_d = '0;
                    base_d    = '0;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    if (NUM_TRIS == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_FETCH;
                        fetch_go_c = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (fetch_done_c) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = WD_W'(TIMEOUT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A real result beats a watchdog expiry in the same cycle.
                if (shader_valid_in) begin
                    color_d = shader_color_in;
                    state_d = S_EMIT;
                end else if (wd_q == '0) begin
                    color_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = S_EMIT;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
            end
            S_EMIT: begin
                if (tri_idx_out == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    tri_idx_d  = tri_idx_out + TRI_W'(1);
                    base_d     = base_q + ADDR_W'(3);
                    state_d    = S_FETCH;
                    fetch_go_c = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        dv_d   = (state_d == S_ISSUE);
        cv_d   = (state_d == S_EMIT);
        done_d = (state_d == S_DONE);
        if (done_d) begin
            busy_d = 1'b0;
        end
    end

endmodule
